// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// ---------------
// Generic pipeline stage register with a valid/ready handshake and a
// two-entry skid buffer. All outputs come straight from flops, so a stage
// never adds a combinational ready path back to the stage upstream of it.
//
// Each entry has a data field and a control field. Whenever a register holds
// a bubble, its control field is zero. This keeps write-enable style control
// bits from leaking into later stages.
//
// Ports
//   clk, rst     clock (rising edge), synchronous active-high reset
//   flush        synchronous squash of every held entry
//   in_valid     upstream entry valid
//   in_ready     stage can accept (registered)
//   in_data      upstream data payload  [DATA_W]
//   in_ctrl      upstream control payload [CTRL_W]
//   out_valid    entry available downstream (registered)
//   out_ready    downstream accepts
//   out_data     held data (registered)
//   out_ctrl     held control (registered, zero while out_valid=0)
//   occupancy    entries held: 0, 1 or 2
//   stall_cnt    saturating count of cycles with out_valid & !out_ready
//   stall_clr    synchronous clear of stall_cnt
//
// Parameters
//   DATA_W, CTRL_W, CNT_W  field widths
//   RESET_DATA             1: data registers cleared on rst, 0: left alone

module pipe_stage_skid #(
  parameter int DATA_W     = 96,
  parameter int CTRL_W     = 8,
  parameter int CNT_W      = 16,
  parameter int RESET_DATA = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  // The state encoding is also the occupancy count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e              state_q,     state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q,  in_ready_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic in_fire;
  logic out_fire;

  // in_ready_q is only low in S_TWO, so in_fire can only happen from
  // S_EMPTY or S_ONE.
  assign in_fire  = in_valid  & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // ---------------------------------------------------------------------
  // Next-state / next-payload
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (flush) begin
      // Drop everything, including an entry arriving this cycle. Data
      // registers keep their contents; only the control fields are cleared.
      // If out_fire is also high, downstream still takes the entry on its
      // side. Nothing extra is needed here.
      state_d     = S_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d     = S_ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end

        S_ONE: begin
          if (in_fire && out_fire) begin
            // Pass-through: replace the departing entry in place.
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (in_fire) begin
            // Downstream stalled. The new entry goes into the skid register
            // because in_ready was already committed high this cycle.
            state_d     = S_TWO;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (out_fire) begin
            state_d     = S_EMPTY;
            main_ctrl_d = '0;
          end
        end

        S_TWO: begin
          if (out_fire) begin
            state_d     = S_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            skid_ctrl_d = '0;
          end
        end

        default: begin
          state_d     = S_EMPTY;
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end

    // Handshake outputs are registered from the next state. This avoids
    // any path from in_* or out_ready to in_ready.
    out_valid_d = (state_d != S_EMPTY);
    in_ready_d  = (state_d != S_TWO);
  end

  // ---------------------------------------------------------------------
  // Back-pressure counter: clear wins over increment, saturates at all-ones
  // ---------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr) begin
      stall_cnt_d = '0;
    end else if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Control state and handshake flops (always reset)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      skid_ctrl_q <= skid_ctrl_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Data flops. Wide stages can drop their reset by setting RESET_DATA=0.
  // Data is never qualified by itself: out_valid and the zeroed control
  // field mark it as meaningless.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst && (RESET_DATA != 0)) begin
      main_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
  localparam int DATA_W = 96;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, out_ready, stall_clr;
  logic              in_ready, out_valid;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W), .RESET_DATA(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a FIFO of at most two entries plus a stall counter.
  entry_t m_q[$];
  int     m_cnt = 0;
  logic   m_in_fire;

  // Advance one clock edge and apply the handshake rules to the model.
  task automatic tick();
    logic fi, fo;
    fi = in_valid && (m_q.size() < 2);
    fo = (m_q.size() > 0) && out_ready;
    @(posedge clk);
    m_in_fire = 1'b0;
    if (rst) begin
      m_q.delete();
      m_cnt = 0;
    end else begin
      if (stall_clr) m_cnt = 0;
      else if (m_q.size() > 0 && !out_ready && m_cnt < CMAX) m_cnt++;
      if (flush) m_q.delete();
      else begin
        if (fo) void'(m_q.pop_front());
        if (fi) begin
          m_q.push_back({in_data, in_ctrl});
          m_in_fire = 1'b1;
        end
      end
    end
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst = 1; flush = 0; in_valid = 1; out_ready = 0; stall_clr = 0;
    in_data = rnd_data(); in_ctrl = 8'hA5;
    tick(); tick();
    rst = 0; in_valid = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL reset_out_ctrl got %h want 0", out_ctrl); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
  endtask

  task automatic test_streaming();
    out_ready = 1;
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1; in_data = DATA_W'(i); in_ctrl = CTRL_W'(i);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== DATA_W'(i) || in_ready !== 1'b1)
        begin errors++; $display("FAIL stream_%0d got v=%b d=%0d rdy=%b want v=1 d=%0d rdy=1", i, out_valid, out_data, in_ready, i); end
    end
    in_valid = 0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] vals[3];
    logic [DATA_W-1:0] got[$];
    int idx;
    vals[0] = 96'hA; vals[1] = 96'hB; vals[2] = 96'hC;
    out_ready = 0; stall_clr = 1; idx = 0;
    in_valid = 1; in_data = vals[0]; in_ctrl = 8'h11;
    tick(); stall_clr = 0;
    idx = 1; in_data = vals[1]; in_ctrl = 8'h22;
    tick();
    idx = 2; in_data = vals[2]; in_ctrl = 8'h33;
    tick();
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== vals[0])
      begin errors++; $display("FAIL bp_full got occ=%0d rdy=%b d=%h want occ=2 rdy=0 d=%h", occupancy, in_ready, out_data, vals[0]); end
    checks++; if (stall_cnt !== CNT_W'(2)) begin errors++; $display("FAIL bp_stall_cnt got %0d want 2", stall_cnt); end
    out_ready = 1;
    for (int c = 0; c < 8; c++) begin
      if (out_valid === 1'b1) got.push_back(out_data);
      tick();
      if (m_in_fire) in_valid = 0;
    end
    checks++; if (got.size() != 3 || got[0] !== vals[0] || got[1] !== vals[1] || got[2] !== vals[2])
      begin errors++; $display("FAIL bp_order got %0d entries first=%h want A,B,C", got.size(), (got.size() > 0) ? got[0] : '0); end
    checks++; if (stall_cnt !== CNT_W'(2) || int'(stall_cnt) != m_cnt)
      begin errors++; $display("FAIL bp_stall_final got %0d want 2", stall_cnt); end
  endtask

  task automatic test_flush();
    out_ready = 0;
    in_valid = 1; in_data = 96'hE; in_ctrl = 8'hEE; tick();
    in_data = 96'hF; in_ctrl = 8'hFF; tick();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_prefill got %0d want 2", occupancy); end
    in_data = 96'hD; in_ctrl = 8'hDD; flush = 1;
    tick();
    flush = 0; in_valid = 0;
    checks++; if (out_valid !== 1'b0 || out_ctrl !== '0 || occupancy !== 2'd0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_state got v=%b c=%h occ=%0d rdy=%b want 0,00,0,1", out_valid, out_ctrl, occupancy, in_ready); end
    out_ready = 1;
    tick();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
      begin errors++; $display("FAIL flush_no_d got v=%b occ=%0d want 0,0", out_valid, occupancy); end
  endtask

  task automatic test_saturation();
    out_ready = 0; stall_clr = 1;
    in_valid = 1; in_data = 96'h5; in_ctrl = 8'h5; tick();
    stall_clr = 0; in_valid = 0;
    for (int c = 0; c < 20; c++) tick();
    checks++; if (stall_cnt !== CNT_W'(CMAX)) begin errors++; $display("FAIL sat_cnt got %0d want %0d", stall_cnt, CMAX); end
    stall_clr = 1; tick();
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL sat_clr got %0d want 0", stall_cnt); end
    stall_clr = 0; tick();
    checks++; if (stall_cnt !== CNT_W'(1)) begin errors++; $display("FAIL sat_restart got %0d want 1", stall_cnt); end
    out_ready = 1; tick();
  endtask

  task automatic test_bubble();
    out_ready = 1; in_valid = 1; in_data = 96'h77; in_ctrl = 8'hFF;
    tick();
    checks++; if (out_valid !== 1'b1 || out_ctrl !== 8'hFF) begin errors++; $display("FAIL bubble_load got v=%b c=%h want 1,ff", out_valid, out_ctrl); end
    in_valid = 0; tick();
    checks++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin errors++; $display("FAIL bubble_ctrl got v=%b c=%h want 0,00", out_valid, out_ctrl); end
  endtask

  task automatic test_random();
    entry_t exp;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      stall_clr = ($urandom_range(0, 30) == 0);
      in_data   = rnd_data();
      in_ctrl   = CTRL_W'($urandom);
      tick();
      exp = (m_q.size() > 0) ? m_q[0] : '0;
      checks++;
      if (out_valid !== (m_q.size() > 0) || in_ready !== (m_q.size() < 2) ||
          occupancy !== 2'(m_q.size()) || out_ctrl !== exp.ctrl ||
          (m_q.size() > 0 && out_data !== exp.data) || int'(stall_cnt) != m_cnt) begin
        errors++;
        $display("FAIL rand_%0d got v=%b r=%b occ=%0d c=%h d=%h cnt=%0d want v=%b r=%b occ=%0d c=%h d=%h cnt=%0d",
                 c, out_valid, in_ready, occupancy, out_ctrl, out_data, stall_cnt,
                 m_q.size() > 0, m_q.size() < 2, m_q.size(), exp.ctrl, exp.data, m_cnt);
      end
    end
    flush = 0; stall_clr = 0; in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_bubble();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with valid/ready handshake, two-entry skid buffer, synchronous flush and a saturating back-pressure counter. It replaces the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block that can stall without combinational ready paths between stages. Payload is split into a data field and a control field; the control field is forced to zero whenever the stage holds a bubble, so that RegWrite/MemWrite style bits never leak.

## Interface
- DATA_W, 96: width of data payload (PC, IR, ALU result, MDR, ...)
- CTRL_W, 8: width of control payload (rd, DatatoReg, RegWrite, ...); all-zero means "no side effects"
- CNT_W, 16: width of back-pressure counter
- RESET_DATA, 1: 1 = data registers cleared on rst; 0 = data registers not reset

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept (registered)
- in_data  in  DATA_W  upstream data
- in_ctrl  in  CTRL_W  upstream control
- out_valid  out  1  entry available downstream (registered)
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  held data (registered)
- out_ctrl  out  CTRL_W  held control (registered; zero when out_valid=0)
- occupancy  out  2  entries held: 0, 1 or 2
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
- stall_clr  in  1  synchronous clear of stall_cnt

## Operation
- Storage: main register (drives out_*) and skid register. in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States: EMPTY (occupancy 0), ONE (main valid), TWO (main and skid valid).
- EMPTY: in_fire -> ONE, main <= in. Else stay.
- ONE: in_fire & out_fire -> ONE, main <= in. in_fire & !out_fire -> TWO, skid <= in. !in_fire & out_fire -> EMPTY, main ctrl <= 0. Neither -> hold.
- TWO: in_ready=0. out_fire -> ONE, main <= skid, skid ctrl <= 0. Else hold.
- in_ready = (state != TWO), registered from next state.
- flush (when rst=0): next state EMPTY, all ctrl registers <= 0, out_valid <= 0, in_ready <= 1; data registers keep value; any in_fire in the same cycle is dropped; an out_fire in the same cycle still counts as accepted downstream.
- rst: state EMPTY, ctrl <= 0, data <= 0 if RESET_DATA=1, stall_cnt <= 0. rst overrides flush and stall_clr.
- stall_cnt: +1 each cycle out_valid & !out_ready; holds at 2^CNT_W-1; stall_clr sets 0 (clear wins over increment in same cycle).
- Ordering strictly FIFO; no entry duplicated or lost except by flush.

## Timing
- Reset values: out_valid 0, in_ready 1, out_ctrl 0, occupancy 0, stall_cnt 0, out_data 0 (RESET_DATA=1) else undefined.
- Latency in->out: 1 cycle (entry accepted at edge N visible on out_* after edge N).
- Throughput: 1 entry/cycle with out_ready held high.
- in_ready falls the cycle after the second entry is captured; no combinational path in_* -> in_ready or out_ready -> in_ready.
- Upstream may hold in_valid while in_ready=0; data must be stable only at fire.
- Flush effect visible after the same edge: out_valid=0 next cycle.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, in_ready=1, occupancy=0, stall_cnt=0.
- Streaming: out_ready=1, send data 1..10 back-to-back -> out_data 1..10 in order, one cycle later each, in_ready never low.
- Back-pressure: out_ready=0, send A,B,C -> A,B captured, occupancy=2, in_ready=0, C held upstream; release out_ready -> A,B,C delivered in order, stall_cnt = stalled cycles.
- Flush with occupancy 2 and simultaneous in_valid=1 (D) -> next cycle out_valid=0, out_ctrl=0, occupancy=0, D not delivered.
- Saturation: CNT_W=4, stall 20 cycles -> stall_cnt=15; stall_clr pulse -> 0, then increments from 1.
- Bubble control: after draining to EMPTY with out_ctrl previously 8'hFF -> out_ctrl=0 while out_valid=0.
